// File: rtl/temporizador_nivel2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_nivel2_pkg
// Description : Shared constants, time type and helpers for the level-2
//               microwave cook timer (state encoding, BCD limits).
// Revision    : 1.0 - initial release
// ============================================================================
package temporizador_nivel2_pkg;

   // Timer states
   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_running = 2'd1;
   localparam logic [1:0] c_st_paused  = 2'd2;
   localparam logic [1:0] c_st_done    = 2'd3;

   // BCD limits
   localparam logic [3:0] c_bcd_max          = 4'd9;
   localparam logic [3:0] c_sec_tens_max_def = 4'd5;

   // MM:SS cook time as four BCD digits, most significant first
   typedef struct packed {
      logic [3:0] min_tens;
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } bcd_time_t;

   // True when the keypad digit is a legal BCD value
   function automatic logic is_bcd(input logic [3:0] digit);
      return (digit <= c_bcd_max);
   endfunction

endpackage
`default_nettype wire

// File: rtl/temporizador_nivel2_bcd_decrementador.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_nivel2_bcd_decrementador
// Description : Combinational one-second decrement of an MM:SS BCD time with
//               digit borrow; flags when the input is exactly 00:01.
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_nivel2_bcd_decrementador
   import temporizador_nivel2_pkg::*;
#(
   parameter logic [3:0] SEC_TENS_MAX = c_sec_tens_max_def
) (
   input  bcd_time_t i_cur,
   output bcd_time_t o_nxt,
   output logic      o_is_one
);

   bcd_time_t w_nxt;

   // Ripple the borrow from seconds units up to minutes tens; seconds tens
   // reload with SEC_TENS_MAX so values above 59 are never normalised.
   always_comb begin
      w_nxt = i_cur;
      if (i_cur.sec_ones != 4'd0) begin
         w_nxt.sec_ones = i_cur.sec_ones - 4'd1;
      end else begin
         w_nxt.sec_ones = c_bcd_max;
         if (i_cur.sec_tens != 4'd0) begin
            w_nxt.sec_tens = i_cur.sec_tens - 4'd1;
         end else begin
            w_nxt.sec_tens = SEC_TENS_MAX;
            if (i_cur.min_ones != 4'd0) begin
               w_nxt.min_ones = i_cur.min_ones - 4'd1;
            end else begin
               w_nxt.min_ones = c_bcd_max;
               w_nxt.min_tens = i_cur.min_tens - 4'd1;
            end
         end
      end
   end

   assign o_nxt    = w_nxt;
   assign o_is_one = (i_cur == {4'd0, 4'd0, 4'd0, 4'd1});

endmodule
`default_nettype wire

// File: rtl/temporizador_nivel2.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_nivel2
// Description : Level-2 microwave cook timer. Assembles an MM:SS time from
//               keypad BCD digits, counts it down on each 1 Hz tick under
//               start/stop/clear control and drives display and status.
//               Optional macro DONE_BEEP_EN adds a completion beep lasting
//               BEEP_TICKS ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_nivel2
   import temporizador_nivel2_pkg::*;
#(
   parameter logic [3:0] SEC_TENS_MAX = c_sec_tens_max_def,
   parameter int         BEEP_TICKS   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       p_1hz,
   input  logic       startn,
   input  logic       stopn,
   input  logic       clearn,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       magnetron_on,
   output logic       done,
   output logic       beep
);

   logic [1:0] r_state;
   bcd_time_t  r_time;
   logic       r_loadn_q;
   logic       r_p_q;

   logic [1:0] w_state_nxt;
   bcd_time_t  w_time_nxt;
   bcd_time_t  w_time_dec;
   logic       w_is_one;
   logic       w_load_ev;
   logic       w_tick_ev;
   logic       w_time_zero;

   assign w_load_ev   = r_loadn_q & ~loadn;
   assign w_tick_ev   = ~r_p_q & p_1hz;
   assign w_time_zero = (r_time == '0);

   temporizador_nivel2_bcd_decrementador #(
      .SEC_TENS_MAX (SEC_TENS_MAX)
   ) u_dec (
      .i_cur    (r_time),
      .o_nxt    (w_time_dec),
      .o_is_one (w_is_one)
   );

   // Next state and digits; clear beats stop beats start beats tick beats load
   always_comb begin
      w_state_nxt = r_state;
      w_time_nxt  = r_time;
      if (!clearn) begin
         w_state_nxt = c_st_idle;
         w_time_nxt  = '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (!startn) begin
                  if (!w_time_zero) begin
                     w_state_nxt = c_st_running;
                  end
               end else if (w_load_ev && is_bcd(D)) begin
                  w_time_nxt = {r_time.min_ones, r_time.sec_tens,
                                r_time.sec_ones, D};
               end
            end
            c_st_running: begin
               if (!stopn) begin
                  w_state_nxt = c_st_paused;
               end else if (w_tick_ev) begin
                  w_time_nxt = w_time_dec;
                  if (w_is_one) begin
                     w_state_nxt = c_st_done;
                  end
               end
            end
            c_st_paused: begin
               if (!startn) begin
                  w_state_nxt = c_st_running;
               end
            end
            default: begin
               // A new key press after completion starts a fresh entry
               if (w_load_ev) begin
                  w_state_nxt = c_st_idle;
                  w_time_nxt  = {4'd0, 4'd0, 4'd0, D};
               end
            end
         endcase
      end
   end

   // State, digit and edge-detect registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_st_idle;
         r_time    <= '0;
         r_loadn_q <= 1'b1;
         r_p_q     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_time    <= w_time_nxt;
         r_loadn_q <= loadn;
         r_p_q     <= p_1hz;
      end
   end

   assign sec_ones     = r_time.sec_ones;
   assign sec_tens     = r_time.sec_tens;
   assign min_ones     = r_time.min_ones;
   assign min_tens     = r_time.min_tens;
   assign magnetron_on = (r_state == c_st_running);
   assign done         = (r_state == c_st_done);

`ifdef DONE_BEEP_EN
   generate
      if (1) begin : g_beep
         localparam int c_cnt_w = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;

         logic               r_beep;
         logic [c_cnt_w-1:0] r_beep_cnt;

         // Beep starts on entry to DONE and drops after BEEP_TICKS ticks
         // spent in DONE, or immediately when DONE is left.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_beep     <= 1'b0;
               r_beep_cnt <= '0;
            end else if (r_state != c_st_done && w_state_nxt == c_st_done) begin
               r_beep     <= 1'b1;
               r_beep_cnt <= c_cnt_w'(BEEP_TICKS);
            end else if (r_state == c_st_done && w_state_nxt != c_st_done) begin
               r_beep     <= 1'b0;
               r_beep_cnt <= '0;
            end else if (r_state == c_st_done && w_tick_ev && r_beep) begin
               r_beep_cnt <= r_beep_cnt - c_cnt_w'(1);
               if (r_beep_cnt <= c_cnt_w'(1)) begin
                  r_beep <= 1'b0;
               end
            end
         end

         assign beep = r_beep;
      end
   endgenerate
`else
   generate
      if (1) begin : g_no_beep
         // No beep hardware; the tick count has no effect in this build
         assign beep = 1'b0 & (|BEEP_TICKS);
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: doc/temporizador_nivel2.md
Name: temporizador_nivel2

Overview:
- Consumer end of the level-2 keypad/clock interface.
- Takes the BCD digit stream (D with loadn strobe) and the 1 Hz pulse (p_1hz) from the keyboard-entry/clock block.
- Assembles an MM:SS cook time from the digits and counts it down once per p_1hz tick under start/stop/clear control.
- Drives the BCD display digits and the magnetron/done status of the microwave controller.

Parameters:
- SEC_TENS_MAX, 5, value loaded into sec_tens when a seconds borrow occurs.
- BEEP_TICKS, 3, number of p_1hz ticks the beep output stays high after completion (only with DONE_BEEP_EN).

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- D  input  4  BCD digit from keypad encoder
- loadn  input  1  active-low digit strobe; high-to-low transition means a new digit is on D
- p_1hz  input  1  1 Hz tick; rising transition equals one second
- startn  input  1  active-low start/resume, level-sampled
- stopn  input  1  active-low pause, level-sampled
- clearn  input  1  active-low clear, level-sampled
- sec_ones  output  4  BCD seconds units
- sec_tens  output  4  BCD seconds tens
- min_ones  output  4  BCD minutes units
- min_tens  output  4  BCD minutes tens
- magnetron_on  output  1  high while in RUNNING
- done  output  1  high while in DONE
- beep  output  1  completion tone (DONE_BEEP_EN only; otherwise tied 0)

Behaviour:
- Clocking and reset:
  - One clock domain, clk. Reset is synchronous and active-high.
  - On reset: all digits 0, state IDLE, magnetron_on=0, done=0, beep=0, edge-detect registers = 1 (loadn_q) and 0 (p_q).
- Edge detection:
  - load_ev = loadn_q & ~loadn.
  - tick_ev = ~p_q & p_1hz.
  - Both registers update every cycle.
- States: IDLE (time entry), RUNNING, PAUSED, DONE.
- Control priority per cycle: reset > clearn > stopn > startn > tick_ev > load_ev.
- clearn=0 (any state): all digits 0, state IDLE.
- load_ev in IDLE:
  - If D<=9, shift left one digit: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D.
  - D>9 is ignored.
  - New value is visible the cycle after the edge.
- load_ev in DONE: digits become 0,0,0,D; state goes to IDLE (a fresh entry starts).
- load_ev in RUNNING or PAUSED: ignored.
- startn=0:
  - IDLE with nonzero time -> RUNNING.
  - IDLE with 00:00 -> stays IDLE.
  - PAUSED -> RUNNING.
  - Ignored in RUNNING and DONE.
- stopn=0: RUNNING -> PAUSED, digits held. Ignored in other states.
- tick_ev in RUNNING, BCD decrement with borrow:
  - sec_ones>0: sec_ones-1.
  - Otherwise sec_ones=9, then borrow into sec_tens: sec_tens>0 gives sec_tens-1, else sec_tens=SEC_TENS_MAX with a borrow into minutes.
  - Minutes: min_ones>0 gives min_ones-1, else min_ones=9 and min_tens-1.
  - A value of 00:01 before the tick gives 00:00 and state DONE in the same cycle.
- Entered seconds above 59 (e.g. 99) are legal and count down through 90, 89, ... without normalisation.
- Simultaneous stopn=0 and tick_ev in RUNNING: stop wins, no decrement.
- tick_ev outside RUNNING: ignored.
- Outputs:
  - magnetron_on = (state==RUNNING).
  - done = (state==DONE).
  - Both are decoded from the registered state, so they change the cycle after the transition trigger.
- Reset asserted mid-countdown returns to the reset values on the next edge.

Optional Feature:
- Macro: DONE_BEEP_EN.
- Defined:
  - On entry to DONE, beep=1 and an internal counter loads BEEP_TICKS.
  - Each tick_ev in DONE decrements the counter; beep drops when it reaches 0.
  - Leaving DONE (clearn or load_ev) forces beep=0.
- Undefined: no counter is built and beep is constant 0.

Decomposition:
- Shared package (nivel2 constants):
  - State encoding IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, DONE=2'd3.
  - BCD_MAX=4'd9 and SEC_TENS_MAX default.
- One natural sub-module: bcd_decrementador.
  - Combinational 4-digit BCD decrement with borrow.
  - Outputs the next digits and an is_one flag (input equals 00:01).
  - Instantiated once by the FSM.

Test Plan:
- Entry: loadn pulses with D=1,3,0 in IDLE -> digits 01:30 after the third edge; a D=4'hA pulse leaves 01:30.
- Countdown: 00:03 entered, startn=0, then 3 p_1hz rises -> 00:02, 00:01, 00:00; done=1 and magnetron_on=0 after the third tick.
- Borrow: 10:00 running, one tick -> 09:59; 01:00 -> 00:59.
- Pause/resume: running 00:10, stopn=0 coincident with a tick -> stays 00:10, state PAUSED; startn=0 plus 2 ticks -> 00:08.
- Clear/guards: startn=0 at 00:00 -> stays IDLE, magnetron_on=0; clearn=0 while running 05:00 -> 00:00 IDLE; loadn edge in DONE with D=7 -> 00:07 IDLE.
- DONE_BEEP_EN with BEEP_TICKS=3: completion -> beep=1 for exactly 3 ticks then 0; synchronous reset mid-beep -> beep=0 next cycle.
